multicycle_controller: RTL and testbench

- Multicycle FSM controller for the RV32I-subset core.
- Sequences one shared ALU, one unified instruction/data memory port and the PC/IR/register-file write enables across several cycles per instruction.
- Supports lw, sw, R-type ALU, I-type ALU, beq/bne and jal.
- Adds a memory-ready handshake and an illegal-opcode trap. Sits beside the multicycle datapath and replaces the single-cycle decode path.

---
 rtl/riscv_ctrl_pkg.sv | 67 ++++++
 rtl/multicycle_controller_if.sv | 37 +++
 rtl/multicycle_controller_alu_dec.sv | 31 +++
 rtl/multicycle_controller.sv | 149 ++++++++++++++
 tb/tb_multicycle_controller.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller: the state enum,
// opcode constants and the mux/ALU select encodings the datapath expects.
package riscv_ctrl_pkg;

    localparam int OP_W    = 7;
    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BR  = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, never on the FSM state.
    function automatic logic [1:0] imm_src_of(input logic [OP_W-1:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BR:   return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle. The controller is the master: it consumes
// instruction fields and status, and drives every enable and select.
interface multicycle_controller_if;
    import riscv_ctrl_pkg::*;

    logic [OP_W-1:0] op;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            Zero;
    logic            mem_ready;

    logic            PCWrite;
    logic            AdrSrc;
    logic            MemWrite;
    logic            IRWrite;
    logic            RegWrite;
    logic [1:0]      ResultSrc;
    logic [1:0]      ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [2:0]      ALUControl;
    logic [1:0]      ImmSrc;
    logic            illegal_instr;
    logic            instr_retired;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_instr, instr_retired
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_instr, instr_retired
    );

endinterface

// File: rtl/multicycle_controller_alu_dec.sv
// ALU decoder: maps the FSM's ALUOp plus instruction fields to an ALU opcode.
module ALU_Decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // funct3=000 is sub only for R-type (op5) with funct7b5; addi ignores bit 30.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FSM controller: sequences the shared ALU, unified memory port and
// PC/IR/register-file enables, with a memory-ready handshake and illegal trap.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);

    state_t     state, next_state;
    logic       illegal_q;

    logic       pc_write, ir_write, reg_write, mem_write, retire;
    logic       adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] alu_control;

    // State register; reset lands in FETCH regardless of where we were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= next_state;
    end

    // Sticky trap flag, set on entry to TRAP and cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  illegal_q <= 1'b0;
        else if (next_state == TRAP) illegal_q <= 1'b1;
    end

    // Next-state logic; memory states hold until mem_ready.
    always_comb begin
        next_state = state;
        case (state)
            FETCH:    if (bus.mem_ready) next_state = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECR;
                    OP_I:         next_state = EXECI;
                    OP_BR:        next_state = BRANCH;
                    OP_JAL:       next_state = JAL;
                    default:      next_state = TRAP;
                endcase
            end
            MEMADR:   next_state = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (bus.mem_ready) next_state = MEMWB;
            MEMWB:    next_state = FETCH;
            MEMWRITE: if (bus.mem_ready) next_state = FETCH;
            EXECR:    next_state = ALUWB;
            EXECI:    next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BRANCH:   next_state = FETCH;
            JAL:      next_state = ALUWB;
            TRAP:     next_state = TRAP;
            default:  next_state = FETCH;
        endcase
    end

    // Moore output decode (mem_ready / Zero qualify a few enables).
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        retire     = 1'b0;
        adr_src    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        case (state)
            FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = bus.mem_ready;
                pc_write   = bus.mem_ready;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = bus.mem_ready;
            end
            EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNC;
            end
            EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNC;
            end
            ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                // funct3[0] flips the sense: beq takes on Zero, bne on !Zero.
                pc_write  = bus.Zero ^ bus.funct3[0];
                retire    = 1'b1;
            end
            JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    ALU_Decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .op5         (bus.op[5]),
        .alu_control (alu_control)
    );

    // State-changing strobes are gated by rst_n so reset kills them instantly.
    assign bus.PCWrite       = rst_n & pc_write;
    assign bus.IRWrite       = rst_n & ir_write;
    assign bus.RegWrite      = rst_n & reg_write;
    assign bus.MemWrite      = rst_n & mem_write;
    assign bus.instr_retired = rst_n & retire;
    assign bus.AdrSrc        = adr_src;
    assign bus.ResultSrc     = result_src;
    assign bus.ALUSrcA       = alu_src_a;
    assign bus.ALUSrcB       = alu_src_b;
    assign bus.ALUControl    = alu_control;
    assign bus.ImmSrc        = imm_src_of(bus.op);
    assign bus.illegal_instr = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expectations
// are queued at issue and compared when the instruction retires.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         lat;
        int         mw;
        int         pcw;
        int         rw;
        logic [2:0] aluc;
        logic [1:0] rsrc;
        logic [1:0] imm;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Issue one instruction starting in FETCH. fw = fetch wait cycles,
    // mw = wait cycles in the memory state (which starts at cycle 3+fw).
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int fw, input int mw,
                             input int e_lat, input int e_mw, input int e_pcw, input int e_rw,
                             input logic [2:0] e_aluc, input logic [1:0] e_rsrc,
                             input logic [1:0] e_imm);
        exp_t       e;
        int         k;
        int         mw_cnt, pcw_cnt, rw_cnt, irw_cnt;
        logic [2:0] aluc;
        logic [1:0] rsrc, imm;
        bit         done;
        e = '{tag, e_lat + fw + mw, e_mw, e_pcw, e_rw, e_aluc, e_rsrc, e_imm};
        sb.push_back(e);
        bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
        k = 0; done = 0; mw_cnt = 0; pcw_cnt = 0; rw_cnt = 0; irw_cnt = 0;
        aluc = '0; rsrc = '0; imm = '0;
        while (!done && k < 60) begin
            @(negedge clk);
            bus.mem_ready = !((k < fw) || (k >= 3 + fw && k < 3 + fw + mw));
            #1;
            mw_cnt  += int'(bus.MemWrite);
            pcw_cnt += int'(bus.PCWrite);
            rw_cnt  += int'(bus.RegWrite);
            irw_cnt += int'(bus.IRWrite);
            if (k == 0) imm = bus.ImmSrc;
            if (k == 2 + fw) aluc = bus.ALUControl;
            if (bus.instr_retired) begin
                done = 1;
                rsrc = bus.ResultSrc;
            end
            k++;
        end
        chk({tag, ".retired"}, 32'(done), 32'd1);
        e = sb.pop_front();
        chk({e.tag, ".lat"},  k,       e.lat);
        chk({e.tag, ".mw"},   mw_cnt,  e.mw);
        chk({e.tag, ".pcw"},  pcw_cnt, e.pcw);
        chk({e.tag, ".rw"},   rw_cnt,  e.rw);
        chk({e.tag, ".irw"},  irw_cnt, 1);
        chk({e.tag, ".aluc"}, aluc,    e.aluc);
        chk({e.tag, ".rsrc"}, rsrc,    e.rsrc);
        chk({e.tag, ".imm"},  imm,     e.imm);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.op = OP_LW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
        bus.Zero = 1'b0; bus.mem_ready = 1'b1;
        #1;
        chk("rst.pcw",  bus.PCWrite, 0);
        chk("rst.irw",  bus.IRWrite, 0);
        chk("rst.ret",  bus.instr_retired, 0);
        chk("rst.ill",  bus.illegal_instr, 0);
        chk("rst.srcb", bus.ALUSrcB, 2'b10);
        chk("rst.rsrc", bus.ResultSrc, 2'b10);
        chk("rst.adr",  bus.AdrSrc, 0);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        //        tag       op      f3      f7 z  fw mw lat mw pcw rw aluc    rsrc   imm
        run_instr("lw",     OP_LW,  3'b010, 0, 0, 0, 0, 5,  0, 1,  1, 3'b000, 2'b01, 2'b00);
        run_instr("lw_w",   OP_LW,  3'b010, 0, 0, 2, 1, 5,  0, 1,  1, 3'b000, 2'b01, 2'b00);
        run_instr("sw_w",   OP_SW,  3'b010, 0, 0, 0, 2, 4,  3, 1,  0, 3'b000, 2'b00, 2'b01);
        run_instr("sw",     OP_SW,  3'b010, 0, 0, 1, 0, 4,  1, 1,  0, 3'b000, 2'b00, 2'b01);
        run_instr("sub",    OP_R,   3'b000, 1, 0, 0, 0, 4,  0, 1,  1, 3'b001, 2'b00, 2'b00);
        run_instr("add",    OP_R,   3'b000, 0, 0, 0, 0, 4,  0, 1,  1, 3'b000, 2'b00, 2'b00);
        run_instr("slt",    OP_R,   3'b010, 0, 0, 0, 0, 4,  0, 1,  1, 3'b101, 2'b00, 2'b00);
        run_instr("or",     OP_R,   3'b110, 0, 0, 0, 0, 4,  0, 1,  1, 3'b011, 2'b00, 2'b00);
        run_instr("and",    OP_R,   3'b111, 0, 0, 0, 0, 4,  0, 1,  1, 3'b010, 2'b00, 2'b00);
        run_instr("xor",    OP_R,   3'b100, 0, 0, 0, 0, 4,  0, 1,  1, 3'b000, 2'b00, 2'b00);
        run_instr("addi",   OP_I,   3'b000, 1, 0, 0, 0, 4,  0, 1,  1, 3'b000, 2'b00, 2'b00);
        run_instr("beq_t",  OP_BR,  3'b000, 0, 1, 0, 0, 3,  0, 2,  0, 3'b001, 2'b00, 2'b10);
        run_instr("beq_nt", OP_BR,  3'b000, 0, 0, 0, 0, 3,  0, 1,  0, 3'b001, 2'b00, 2'b10);
        run_instr("bne_t",  OP_BR,  3'b001, 0, 0, 0, 0, 3,  0, 2,  0, 3'b001, 2'b00, 2'b10);
        run_instr("bne_nt", OP_BR,  3'b001, 0, 1, 0, 0, 3,  0, 1,  0, 3'b001, 2'b00, 2'b10);
        run_instr("jal",    OP_JAL, 3'b000, 0, 0, 0, 0, 4,  0, 2,  1, 3'b000, 2'b00, 2'b11);

        // Illegal opcode: FETCH, DECODE, then absorbing TRAP.
        bus.op = 7'b0000000; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bus.mem_ready = 1'b1;
            #1;
            if (k == 1) chk("trap.pre_ill", bus.illegal_instr, 0);
            if (k >= 2) begin
                chk("trap.ill", bus.illegal_instr, 1);
                chk("trap.en", {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite,
                                bus.instr_retired}, 5'b0);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("trap.rst_ill", bus.illegal_instr, 0);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run_instr("post_trap", OP_I, 3'b111, 0, 0, 0, 0, 4, 0, 1, 1, 3'b010, 2'b00, 2'b00);

        // Reset while stalled in MEMWRITE must drop MemWrite at once.
        bus.op = OP_SW; bus.funct3 = 3'b010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.mem_ready = (k < 3);
            #1;
        end
        chk("arst.mw_before", bus.MemWrite, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst.mw_async", bus.MemWrite, 0);
        chk("arst.adr",      bus.AdrSrc, 0);
        bus.mem_ready = 1'b1;
        #1;
        chk("arst.irw_forced", bus.IRWrite, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        chk("arst.irw_lo", bus.IRWrite, 0);
        chk("arst.mw_lo",  bus.MemWrite, 0);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        chk("arst.irw_hi", bus.IRWrite, 1);
        chk("arst.pcw_hi", bus.PCWrite, 1);
        chk("arst.mw_hi",  bus.MemWrite, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
